// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns the EX/MEM slot into one data-bus transaction,
// stalls the pipe until the bus answers, and returns aligned, extended load data.
//
//  state | meaning
//  IDLE  | no transaction outstanding; a legal mem op in the slot starts one
//  BUSY  | request on the bus for the live instruction, pipe stalled
//  DRAIN | slot was flushed mid-request; wait out the bus, discard the response
//  DONE  | result valid, waiting for the MEM/WB register to accept it
module mem_access_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flushM,
    input  logic              advance,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              stallM,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              misaligned
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, stateNext;

    logic [ADDR_W-1:0] addrQ;
    logic [1:0]        sizeQ;
    logic              unsignedQ;
    logic              loadQ;
    logic [7:0]        strobeQ;
    logic [DATA_W-1:0] dataQ;
    logic [DATA_W-1:0] rdataQ;

    logic              memOp;
    logic              misalignedRaw;
    logic              start;
    logic              isStore;
    logic [2:0]        offset;
    logic [7:0]        strobeBase;
    logic [7:0]        strobeNew;
    logic [DATA_W-1:0] dataNew;
    logic [DATA_W-1:0] loadWord;
    logic [DATA_W-1:0] loadExt;
    logic              signBit;

    assign memOp   = in_valid & (in_load | in_store);
    assign isStore = in_store & ~in_load;
    assign offset  = in_addr[2:0];

    always_comb begin
        misalignedRaw = 1'b0;
        case (in_size)
            2'd0:    misalignedRaw = 1'b0;
            2'd1:    misalignedRaw = in_addr[0];
            2'd2:    misalignedRaw = |in_addr[1:0];
            default: misalignedRaw = |in_addr[2:0];
        endcase
    end

    assign start = memOp & ~misalignedRaw & ~flushM;

    always_comb begin
        strobeBase = 8'h00;
        case (in_size)
            2'd0:    strobeBase = 8'h01;
            2'd1:    strobeBase = 8'h03;
            2'd2:    strobeBase = 8'h0F;
            default: strobeBase = 8'hFF;
        endcase
    end

    assign strobeNew = isStore ? (strobeBase << offset) : 8'h00;
    assign dataNew   = isStore ? (in_wdata << {offset, 3'b000}) : '0;

    // Response is realigned with the latched offset; the slot may have moved on by now.
    assign loadWord = dresp_data >> {addrQ[2:0], 3'b000};

    always_comb begin
        signBit = 1'b0;
        loadExt = loadWord;
        case (sizeQ)
            2'd0: begin
                signBit = ~unsignedQ & loadWord[7];
                loadExt = {{(DATA_W-8){signBit}}, loadWord[7:0]};
            end
            2'd1: begin
                signBit = ~unsignedQ & loadWord[15];
                loadExt = {{(DATA_W-16){signBit}}, loadWord[15:0]};
            end
            2'd2: begin
                signBit = ~unsignedQ & loadWord[31];
                loadExt = {{(DATA_W-32){signBit}}, loadWord[31:0]};
            end
            default: begin
                signBit = 1'b0;
                loadExt = loadWord;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addrQ     <= '0;
            sizeQ     <= 2'd0;
            unsignedQ <= 1'b0;
            loadQ     <= 1'b0;
            strobeQ   <= 8'h00;
            dataQ     <= '0;
            rdataQ    <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && start) begin
                addrQ     <= in_addr;
                sizeQ     <= in_size;
                unsignedQ <= in_unsigned;
                loadQ     <= in_load;
                strobeQ   <= strobeNew;
                dataQ     <= dataNew;
            end
            if (state == BUSY && dresp_data_ok && !flushM) begin
                rdataQ <= loadQ ? loadExt : '0;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        dreq_valid  = 1'b0;
        stallM      = 1'b0;
        rdata_valid = 1'b0;
        rdata       = '0;
        case (state)
            IDLE: begin
                stallM = start;
                if (start) stateNext = BUSY;
            end
            BUSY: begin
                dreq_valid = 1'b1;
                stallM     = 1'b1;
                // A flush that coincides with the response has nothing left to drain.
                if (flushM)             stateNext = dresp_data_ok ? IDLE : DRAIN;
                else if (dresp_data_ok) stateNext = DONE;
            end
            DRAIN: begin
                dreq_valid = 1'b1;
                if (dresp_data_ok) stateNext = IDLE;
            end
            DONE: begin
                rdata_valid = 1'b1;
                rdata       = rdataQ;
                if (advance || flushM) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (reset) begin
            dreq_valid  = 1'b0;
            stallM      = 1'b0;
            rdata_valid = 1'b0;
            rdata       = '0;
        end
    end

    assign misaligned  = ~reset & memOp & misalignedRaw;
    assign dreq_addr   = addrQ;
    assign dreq_size   = sizeQ;
    assign dreq_strobe = strobeQ;
    assign dreq_data   = dataQ;

endmodule
